// File: rtl/hpi_slave_model.sv
// EZ-OTG responder for the CY7C67200 Host Port Interface: word RAM behind an
// auto-incrementing byte pointer, two one-word mailboxes, STATUS port and OTG_INT.
module hpi_slave_model #(
    parameter int DEPTH_WORDS = 256,
    parameter int PTR_W       = 16
) (
    input  logic        Clk,
    input  logic        Reset_N,
    inout  wire  [15:0] OTG_DATA,
    input  logic [1:0]  OTG_ADDR,
    input  logic        OTG_RD_N,
    input  logic        OTG_WR_N,
    input  logic        OTG_CS_N,
    input  logic        OTG_RST_N,
    output logic        OTG_INT,
    output logic [15:0] h2c_data,
    output logic        h2c_valid,
    input  logic        h2c_ready,
    input  logic [15:0] c2h_data,
    input  logic        c2h_valid,
    output logic        c2h_ready,
    output logic        proto_err,
    output logic        h2c_ovf
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] PORT_DATA = 2'd0;
    localparam logic [1:0] PORT_MBOX = 2'd1;
    localparam logic [1:0] PORT_ADDR = 2'd2;
    localparam logic [1:0] PORT_STAT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ACT, S_HOLD} state_t;

    state_t           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [1:0]       port_q;
    logic             is_wr_q;
    logic             int_clr_q;
    logic             blocked_q;
    logic [15:0]      wdata_q;
    logic [15:0]      rd_q;
    logic [15:0]      c2h_word_q;
    logic [15:0]      h2c_data_q;
    logic             int_q;
    logic             h2c_valid_q;
    logic             proto_err_q;
    logic             h2c_ovf_q;
    logic [15:0]      ram [DEPTH_WORDS];

    logic             rd;
    logic             wr;
    logic             both;
    logic             active;
    logic             start;
    logic             act_ok;
    logic             ram_we;
    logic [AW-1:0]    ptr_idx;
    logic [PTR_W-1:0] addr_wr;

    assign rd      = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;
    assign wr      = ~OTG_CS_N & ~OTG_WR_N & OTG_RD_N;
    assign both    = ~OTG_CS_N & ~OTG_RD_N & ~OTG_WR_N;
    assign active  = rd | wr;
    // blocked_q keeps a strobe that survived a reset from starting an access
    assign start   = (state_q == S_IDLE) & active & ~blocked_q;
    assign act_ok  = (state_q == S_ACT) & ~both;
    assign ram_we  = act_ok & OTG_RST_N & is_wr_q & (port_q == PORT_DATA);
    assign ptr_idx = ptr_q[AW:1];
    assign addr_wr = PTR_W'(wdata_q);

    assign OTG_DATA  = (rd && state_q != S_IDLE) ? rd_q : 16'hzzzz;
    assign OTG_INT   = int_q;
    assign c2h_ready = ~int_q;
    assign h2c_data  = h2c_data_q;
    assign h2c_valid = h2c_valid_q;
    assign proto_err = proto_err_q;
    assign h2c_ovf   = h2c_ovf_q;

    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram[ptr_idx] <= wdata_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (start && OTG_RST_N && !both) begin
            unique case (OTG_ADDR)
                PORT_DATA: rd_q <= ram[ptr_idx];
                PORT_MBOX: rd_q <= c2h_word_q;
                PORT_ADDR: rd_q <= 16'(ptr_q);
                PORT_STAT: rd_q <= {14'b0, h2c_valid_q, int_q};
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            port_q      <= PORT_DATA;
            is_wr_q     <= 1'b0;
            int_clr_q   <= 1'b0;
            blocked_q   <= 1'b1;
            wdata_q     <= '0;
            c2h_word_q  <= '0;
            h2c_data_q  <= '0;
            int_q       <= 1'b0;
            h2c_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            h2c_ovf_q   <= 1'b0;
        end else if (!OTG_RST_N) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            blocked_q   <= 1'b1;
            h2c_data_q  <= '0;
            int_q       <= 1'b0;
            h2c_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            h2c_ovf_q   <= 1'b0;
        end else begin
            if (c2h_valid && !int_q) begin
                c2h_word_q <= c2h_data;
                int_q      <= 1'b1;
            end
            if (h2c_valid_q && h2c_ready) begin
                h2c_valid_q <= 1'b0;
            end
            if (!active) begin
                blocked_q <= 1'b0;
            end

            if (both) begin
                proto_err_q <= 1'b1;
                state_q     <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q   <= S_ACT;
                            port_q    <= OTG_ADDR;
                            is_wr_q   <= wr;
                            wdata_q   <= OTG_DATA;
                            // only a read of a full mailbox consumes it
                            int_clr_q <= rd && (OTG_ADDR == PORT_MBOX) && int_q;
                        end
                    end
                    S_ACT: begin
                        state_q <= S_HOLD;
                        if (int_clr_q) begin
                            int_q <= 1'b0;
                        end
                        unique case (port_q)
                            PORT_DATA: ptr_q <= ptr_q + PTR_W'(2);
                            PORT_MBOX: begin
                                if (is_wr_q) begin
                                    h2c_data_q  <= wdata_q;
                                    h2c_valid_q <= 1'b1;
                                    if (h2c_valid_q && !h2c_ready) begin
                                        h2c_ovf_q <= 1'b1;
                                    end
                                end
                            end
                            PORT_ADDR: begin
                                if (is_wr_q) begin
                                    ptr_q <= {addr_wr[PTR_W-1:1], 1'b0};
                                end
                            end
                            PORT_STAT: ;
                        endcase
                    end
                    S_HOLD: begin
                        if (!active) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hpi_slave_model.sv
// Randomised bench for hpi_slave_model: host HPI cycles and local mailbox traffic are
// scored against an array/flag model of the EZ-OTG register and RAM behaviour.
module tb_hpi_slave_model;
    localparam int DEPTH = 256;
    localparam logic [1:0] P_DATA = 2'd0;
    localparam logic [1:0] P_MBOX = 2'd1;
    localparam logic [1:0] P_ADDR = 2'd2;
    localparam logic [1:0] P_STAT = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  addr;
    logic        rd_n, wr_n, cs_n, otg_rst_n;
    logic        otg_int, h2c_valid, h2c_ready, c2h_valid, c2h_ready, proto_err, h2c_ovf;
    logic [15:0] h2c_data, c2h_data;
    logic [15:0] tb_drv;
    logic        tb_oe;
    wire  [15:0] otg_data;

    assign otg_data = tb_oe ? tb_drv : 16'hzzzz;

    always #5 clk = ~clk;

    hpi_slave_model #(.DEPTH_WORDS(DEPTH), .PTR_W(16)) dut (
        .Clk(clk), .Reset_N(rst_n), .OTG_DATA(otg_data), .OTG_ADDR(addr),
        .OTG_RD_N(rd_n), .OTG_WR_N(wr_n), .OTG_CS_N(cs_n), .OTG_RST_N(otg_rst_n),
        .OTG_INT(otg_int), .h2c_data(h2c_data), .h2c_valid(h2c_valid), .h2c_ready(h2c_ready),
        .c2h_data(c2h_data), .c2h_valid(c2h_valid), .c2h_ready(c2h_ready),
        .proto_err(proto_err), .h2c_ovf(h2c_ovf)
    );

    // reference model
    logic [15:0] m_ram [DEPTH];
    int          m_ptr;
    bit          m_int, m_h2c_valid, m_ovf, m_perr, m_c2h_known;
    logic [15:0] m_c2h, m_h2c_data;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic int midx();
        return (m_ptr / 2) % DEPTH;
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_int = 0; m_h2c_valid = 0; m_h2c_data = 16'h0;
        m_ovf = 0; m_perr = 0; m_c2h_known = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".int"},       32'(otg_int),   32'(m_int));
        chk({tag, ".c2h_ready"}, 32'(c2h_ready), 32'(!m_int));
        chk({tag, ".h2c_valid"}, 32'(h2c_valid), 32'(m_h2c_valid));
        chk({tag, ".h2c_data"},  32'(h2c_data),  32'(m_h2c_data));
        chk({tag, ".ovf"},       32'(h2c_ovf),   32'(m_ovf));
        chk({tag, ".perr"},      32'(proto_err), 32'(m_perr));
    endtask

    // bench drives 0 onto the bus; any DUT drive of nonzero data shows up
    task automatic probe_z(input string tag);
        tb_drv = 16'h0000; tb_oe = 1'b1;
        #1;
        chk(tag, 32'(otg_data), 32'h0);
        tb_oe = 1'b0;
    endtask

    task automatic do_wr(input logic [1:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        addr = a; tb_drv = d; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
        repeat (hold) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
        repeat (2) @(negedge clk);
        case (a)
            P_DATA: begin m_ram[midx()] = d; m_ptr = (m_ptr + 2) % 65536; end
            P_MBOX: begin
                if (m_h2c_valid) m_ovf = 1;
                m_h2c_data = d; m_h2c_valid = 1;
            end
            P_ADDR: m_ptr = int'(d) & 'hFFFE;
            default: ;
        endcase
    endtask

    task automatic do_rd(input logic [1:0] a, input int hold, input string tag);
        logic [15:0] v, e;
        bit          known;
        known = 1;
        case (a)
            P_DATA:  e = m_ram[midx()];
            P_MBOX:  begin e = m_c2h; known = m_c2h_known; end
            P_ADDR:  e = 16'(m_ptr);
            default: e = {14'b0, m_h2c_valid, m_int};
        endcase
        @(negedge clk);
        addr = a; cs_n = 1'b0; rd_n = 1'b0;
        repeat (hold) @(negedge clk);
        v = otg_data;
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(negedge clk);
        if (known) chk(tag, 32'(v), 32'(e));
        if (a == P_DATA) m_ptr = (m_ptr + 2) % 65536;
        if (a == P_MBOX) m_int = 0;
    endtask

    task automatic c2h_push(input logic [15:0] d);
        bit accept;
        accept = !m_int;
        @(negedge clk); c2h_data = d; c2h_valid = 1'b1;
        @(negedge clk); c2h_valid = 1'b0;
        @(negedge clk);
        if (accept) begin m_c2h = d; m_int = 1; m_c2h_known = 1; end
    endtask

    task automatic h2c_pop();
        @(negedge clk); h2c_ready = 1'b1;
        @(negedge clk); h2c_ready = 1'b0;
        @(negedge clk);
        m_h2c_valid = 0;
    endtask

    int          op, h;
    logic [15:0] r;

    initial begin
        rst_n = 1'b0; addr = 2'd0; rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1; otg_rst_n = 1'b1;
        h2c_ready = 1'b0; c2h_valid = 1'b0; c2h_data = 16'h0; tb_drv = 16'h0; tb_oe = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_state("reset");
        probe_z("reset.bus_z");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_rd(P_ADDR, 2, "reset.ptr");

        // basic pointer auto-increment
        do_wr(P_ADDR, 16'h0010, 2);
        do_wr(P_DATA, 16'hAAAA, 2);
        do_wr(P_DATA, 16'hBBBB, 3);
        do_wr(P_ADDR, 16'h0010, 2);
        do_rd(P_DATA, 2, "seq.rd0");
        do_rd(P_DATA, 3, "seq.rd1");
        do_rd(P_ADDR, 2, "seq.ptr");

        // fill the whole RAM so every later read has a known value
        do_wr(P_ADDR, 16'h0000, 2);
        for (int i = 0; i < DEPTH; i++) do_wr(P_DATA, 16'($urandom), 2);
        do_rd(P_ADDR, 2, "fill.ptr_wrapped");

        // long write strobe: one side effect only
        do_wr(P_ADDR, 16'h0020, 2);
        do_wr(P_DATA, 16'h7777, 10);
        do_rd(P_ADDR, 2, "hold10.ptr");
        do_wr(P_ADDR, 16'h0020, 2);
        do_rd(P_DATA, 2, "hold10.word");
        do_rd(P_DATA, 2, "hold10.next_untouched");

        // index and pointer wrap
        do_wr(P_ADDR, 16'(2 * (DEPTH - 1)), 2);
        do_wr(P_DATA, 16'hC0DE, 2);
        do_wr(P_DATA, 16'h5555, 2);
        do_wr(P_ADDR, 16'h0000, 2);
        do_rd(P_DATA, 2, "wrap.word0");
        do_wr(P_ADDR, 16'hFFFE, 2);
        do_rd(P_DATA, 2, "wrap.top");
        do_rd(P_ADDR, 2, "wrap.ptr16");
        do_wr(P_ADDR, 16'h0013, 2);
        do_rd(P_ADDR, 2, "addr.bit0");

        // chip-to-host mailbox
        h2c_pop();
        c2h_push(16'h1234);
        check_state("c2h.full");
        do_rd(P_STAT, 2, "c2h.status");
        do_rd(P_MBOX, 2, "c2h.read");
        check_state("c2h.drained");
        do_rd(P_MBOX, 2, "c2h.read_empty");
        check_state("c2h.still_empty");

        // host-to-chip overflow and protocol error
        do_wr(P_MBOX, 16'h0001, 2);
        do_wr(P_MBOX, 16'h0002, 2);
        check_state("h2c.ovf");
        @(negedge clk);
        addr = P_DATA; tb_drv = 16'hDEAD; tb_oe = 1'b1; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
        repeat (2) @(negedge clk);
        m_perr = 1;
        check_state("perr");
        do_rd(P_ADDR, 2, "perr.ptr_kept");
        do_rd(P_DATA, 2, "perr.ram_kept");

        // host soft reset
        c2h_push(16'h4321);
        @(negedge clk); otg_rst_n = 1'b0;
        @(negedge clk); otg_rst_n = 1'b1;
        @(negedge clk);
        model_clear();
        check_state("softrst");
        do_rd(P_ADDR, 2, "softrst.ptr");

        // host mailbox write lands in the same cycle as a local pop
        do_wr(P_MBOX, 16'h0A0A, 2);
        @(negedge clk);
        addr = P_MBOX; tb_drv = 16'h0B0B; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk); h2c_ready = 1'b1;
        @(negedge clk); h2c_ready = 1'b0; cs_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
        repeat (2) @(negedge clk);
        m_h2c_data = 16'h0B0B; m_h2c_valid = 1;
        check_state("pop_vs_wr");

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 11);
            h  = $urandom_range(2, 4);
            r  = 16'($urandom);
            case (op)
                0, 1:    do_wr(P_DATA, r, h);
                2, 3:    do_rd(P_DATA, h, "rnd.data");
                4:       do_wr(P_ADDR, r, h);
                5:       do_rd(P_ADDR, h, "rnd.addr");
                6:       do_wr(P_MBOX, r, h);
                7:       do_rd(P_MBOX, h, "rnd.mbox");
                8:       do_rd(P_STAT, h, "rnd.stat");
                9:       do_wr(P_STAT, r, h);
                10:      c2h_push(r);
                default: h2c_pop();
            endcase
            check_state("rnd");
        end

        // Reset_N asserted in the middle of a DATA read
        do_wr(P_ADDR, 16'h0040, 2);
        do_wr(P_DATA, 16'hF00D, 2);
        do_wr(P_ADDR, 16'h0040, 2);
        c2h_push(16'h5A5A);
        chk("rstmid.int_pre", 32'(otg_int), 32'(m_int));
        @(negedge clk);
        addr = P_DATA; cs_n = 1'b0; rd_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid.data_pre", 32'(otg_data), 32'hF00D);
        #2 rst_n = 1'b0;
        probe_z("rstmid.bus_z");
        chk("rstmid.int", 32'(otg_int), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        probe_z("rstmid.no_restart");
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(negedge clk);
        model_clear();
        check_state("rstmid");
        do_rd(P_ADDR, 2, "rstmid.ptr");
        do_wr(P_ADDR, 16'h0040, 2);
        do_rd(P_DATA, 2, "rstmid.ram_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
